// File: rtl/cozy_regfile_sb.sv
// Register file with load scoreboard, optional write-to-read bypass and post-reset clear sequencer.
// Latency: reads combinational (0 cycles with bypass, 1 cycle without); busy falls NREGS-1 edges after reset.
// Backpressure: stall is raised while clearing or when a read selects a register awaiting a load.
module cozy_regfile_sb #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] rD_sel,
  input  logic                 rD_we,
  input  logic [WIDTH-1:0]     rD_in,
  output logic [WIDTH-1:0]     rD_out,
  input  logic [ADDR_BITS-1:0] rS_sel,
  output logic [WIDTH-1:0]     rS_out,
  input  logic                 pend_set,
  input  logic [ADDR_BITS-1:0] pend_sel,
  output logic                 stall,
  output logic                 busy
);

  localparam int NREGS = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_REG = ADDR_BITS'(NREGS - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
  logic                  clr_en;

  // Register 0 has no storage; it is hardwired to read as zero.
  logic [WIDTH-1:0]      mem [1:NREGS-1];
  logic [NREGS-1:1]      pend_q;

  logic                  wr_req;
  logic                  wr_acc;
  logic                  set_acc;
  logic [WIDTH-1:0]      rd_mem, rs_mem;
  logic                  rd_pend, rs_pend;
  logic                  rd_byp, rs_byp;

  assign busy    = (state_q == ST_CLEAR);
  assign wr_req  = rD_we && (rD_sel != '0);
  assign wr_acc  = wr_req && !busy;
  assign set_acc = pend_set && (pend_sel != '0) && !busy;

  // Sequencer state register; reset restarts the clear from register 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= ADDR_BITS'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state: walk cnt up to the last register, then hand over to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_en = 1'b1;
        if (cnt_q == LAST_REG) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + ADDR_BITS'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Storage: zeroed one entry per edge while clearing, otherwise written by accepted writes.
  // Not reset, so a reset edge leaves contents alone until the sequencer reaches them.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NREGS; i++) begin
      if (!rst) begin
        if (clr_en && (cnt_q == ADDR_BITS'(i))) begin
          mem[i] <= '0;
        end else if (wr_acc && (rD_sel == ADDR_BITS'(i))) begin
          mem[i] <= rD_in;
        end
      end
    end
  end

  // Scoreboard: a write is the load return and clears the bit, but a new load to the same register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (set_acc && (pend_sel == ADDR_BITS'(i))) begin
          pend_q[i] <= 1'b1;
        end else if (wr_acc && (rD_sel == ADDR_BITS'(i))) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  // Read muxes over stored values and pending bits; selector 0 falls through to zero / not pending.
  always_comb begin
    rd_mem  = '0;
    rs_mem  = '0;
    rd_pend = 1'b0;
    rs_pend = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (rD_sel == ADDR_BITS'(i)) begin
        rd_mem  = mem[i];
        rd_pend = pend_q[i];
      end
      if (rS_sel == ADDR_BITS'(i)) begin
        rs_mem  = mem[i];
        rs_pend = pend_q[i];
      end
    end
  end

  assign rd_byp = (BYPASS != 0) && wr_req;
  assign rs_byp = (BYPASS != 0) && wr_req && (rS_sel == rD_sel);

  // Output ports: zero while clearing, forwarded write data when bypassing, else the stored value.
  always_comb begin
    rD_out = '0;
    rS_out = '0;
    if (!busy) begin
      if (rd_byp) begin
        rD_out = rD_in;
      end else begin
        rD_out = rd_mem;
      end
      if (rs_byp) begin
        rS_out = rD_in;
      end else begin
        rS_out = rs_mem;
      end
    end
  end

  // A bypassed port reading the register being written this cycle is not stalled by its pending bit.
  assign stall = busy
               || (rd_pend && !(rd_byp && wr_acc))
               || (rs_pend && !(rs_byp && wr_acc));

endmodule

// File: tb/tb_cozy_regfile_sb.sv
module tb_cozy_regfile_sb;

  logic        clk;
  logic        rst;
  logic [3:0]  rD_sel;
  logic        rD_we;
  logic [15:0] rD_in;
  logic [3:0]  rS_sel;
  logic        pend_set;
  logic [3:0]  pend_sel;

  logic [15:0] rd_out1, rs_out1, rd_out0, rs_out0;
  logic        stall1, stall0, busy1, busy0;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural contents, pending flags and edges left in the clear.
  logic [15:0] m_mem  [0:15];
  bit          m_pend [0:15];
  int          m_clr_left = 15;

  cozy_regfile_sb #(.WIDTH(16), .ADDR_BITS(4), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rD_sel(rD_sel), .rD_we(rD_we), .rD_in(rD_in),
    .rD_out(rd_out1), .rS_sel(rS_sel), .rS_out(rs_out1), .pend_set(pend_set),
    .pend_sel(pend_sel), .stall(stall1), .busy(busy1)
  );

  cozy_regfile_sb #(.WIDTH(16), .ADDR_BITS(4), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .rD_sel(rD_sel), .rD_we(rD_we), .rD_in(rD_in),
    .rD_out(rd_out0), .rS_sel(rS_sel), .rS_out(rs_out0), .pend_set(pend_set),
    .pend_sel(pend_sel), .stall(stall0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_rd(input logic [3:0] sel, input bit byp);
    if (m_clr_left > 0) return 16'h0;
    if (sel == 4'd0) return 16'h0;
    if (byp && rD_we && (rD_sel == sel)) return rD_in;
    return m_mem[sel];
  endfunction

  function automatic logic exp_stall(input bit byp);
    bit s;
    if (m_clr_left > 0) return 1'b1;
    s = 1'b0;
    if (rD_sel != 4'd0 && m_pend[rD_sel] && !(byp && rD_we)) s = 1'b1;
    if (rS_sel != 4'd0 && m_pend[rS_sel] && !(byp && rD_we && rD_sel != 4'd0 && rS_sel == rD_sel)) s = 1'b1;
    return s;
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      m_clr_left = 15;
      for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    end else if (m_clr_left > 0) begin
      m_clr_left--;
      if (m_clr_left == 0) for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
    end else begin
      if (rD_we && rD_sel != 4'd0) begin
        m_mem[rD_sel]  = rD_in;
        m_pend[rD_sel] = 1'b0;
      end
      if (pend_set && pend_sel != 4'd0) m_pend[pend_sel] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rD_we = 1'b0; rD_sel = 4'd0; rD_in = 16'h0;
    rS_sel = 4'd0; pend_set = 1'b0; pend_sel = 4'd0;
  endtask

  task automatic write_reg(input logic [3:0] sel, input logic [15:0] val);
    rD_we = 1'b1; rD_sel = sel; rD_in = val;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy1); end
    checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL reset_stall got=%b exp=1", stall1); end
    checks++; if (rd_out1 !== 16'h0 || rs_out1 !== 16'h0) begin errors++; $display("FAIL reset_reads got=%h/%h exp=0", rd_out1, rs_out1); end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    write_reg(4'd5, 16'hBEEF);
    write_reg(4'd15, 16'h1234);
    rS_sel = 4'd5; #1;
    checks++; if (rs_out1 !== 16'hBEEF) begin errors++; $display("FAIL preload_r5 got=%h exp=beef", rs_out1); end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    for (int i = 0; i < 15; i++) begin
      checks++; if (busy1 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL clear_busy_hi edge=%0d got=%b/%b exp=1", i, busy1, busy0); end
      tick();
    end
    checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL clear_busy_lo got=%b/%b exp=0", busy1, busy0); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL clear_stall got=%b exp=0", stall1); end
    rD_sel = 4'd5; rS_sel = 4'd15; #1;
    checks++; if (rd_out1 !== 16'h0 || rs_out1 !== 16'h0) begin errors++; $display("FAIL clear_r5_r15 got=%h/%h exp=0", rd_out1, rs_out1); end
    idle();
  endtask

  task automatic test_bypass();
    write_reg(4'd3, 16'h1111);
    rD_we = 1'b1; rD_sel = 4'd3; rD_in = 16'hA5A5; rS_sel = 4'd3; #1;
    checks++; if (rs_out1 !== 16'hA5A5) begin errors++; $display("FAIL bypass_rs got=%h exp=a5a5", rs_out1); end
    checks++; if (rd_out1 !== 16'hA5A5) begin errors++; $display("FAIL bypass_rd got=%h exp=a5a5", rd_out1); end
    checks++; if (rs_out0 !== 16'h1111) begin errors++; $display("FAIL nobypass_old got=%h exp=1111", rs_out0); end
    tick();
    rD_we = 1'b0; #1;
    checks++; if (rs_out0 !== 16'hA5A5) begin errors++; $display("FAIL nobypass_new got=%h exp=a5a5", rs_out0); end
    idle();
  endtask

  task automatic test_zero();
    logic [15:0] snap [0:15];
    for (int r = 1; r < 16; r++) write_reg(4'(r), 16'(r * 16'h0101));
    for (int r = 1; r < 16; r++) snap[r] = 16'(r * 16'h0101);
    rD_we = 1'b1; rD_sel = 4'd0; rD_in = 16'hFFFF; rS_sel = 4'd0; #1;
    checks++; if (rd_out1 !== 16'h0 || rs_out1 !== 16'h0) begin errors++; $display("FAIL zero_bypass got=%h/%h exp=0", rd_out1, rs_out1); end
    tick();
    idle();
    for (int r = 1; r < 16; r++) begin
      rS_sel = 4'(r); #1;
      checks++; if (rs_out0 !== snap[r]) begin errors++; $display("FAIL zero_unchanged r=%0d got=%h exp=%h", r, rs_out0, snap[r]); end
    end
    idle();
  endtask

  task automatic test_scoreboard();
    pend_set = 1'b1; pend_sel = 4'd7;
    tick();
    idle(); rS_sel = 4'd7; #1;
    checks++; if (stall1 !== 1'b1 || stall0 !== 1'b1) begin errors++; $display("FAIL sb_pending got=%b/%b exp=1", stall1, stall0); end
    rD_we = 1'b1; rD_sel = 4'd7; rD_in = 16'h0042; #1;
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL sb_masked got=%b exp=0", stall1); end
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL sb_nomask got=%b exp=1", stall0); end
    checks++; if (rs_out1 !== 16'h0042) begin errors++; $display("FAIL sb_return_data got=%h exp=0042", rs_out1); end
    tick();
    idle(); rS_sel = 4'd7; #1;
    checks++; if (stall1 !== 1'b0 || stall0 !== 1'b0) begin errors++; $display("FAIL sb_cleared got=%b/%b exp=0", stall1, stall0); end
    rD_we = 1'b1; rD_sel = 4'd7; rD_in = 16'h0055; pend_set = 1'b1; pend_sel = 4'd7;
    tick();
    idle(); rS_sel = 4'd7; #1;
    checks++; if (stall1 !== 1'b1 || stall0 !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b/%b exp=1", stall1, stall0); end
    idle(); rD_we = 1'b1; rD_sel = 4'd7; rD_in = 16'h0066; #1;
    checks++; if (stall1 !== 1'b0 || stall0 !== 1'b1) begin errors++; $display("FAIL sb_rd_port got=%b/%b exp=0/1", stall1, stall0); end
    tick();
    idle(); rD_sel = 4'd7; #1;
    checks++; if (stall1 !== 1'b0 || rd_out0 !== 16'h0066) begin errors++; $display("FAIL sb_final got=%b/%h exp=0/0066", stall1, rd_out0); end
    idle();
  endtask

  task automatic test_busy_block();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rD_we = 1'b1; rD_sel = 4'd2; rD_in = 16'h1111; pend_set = 1'b1; pend_sel = 4'd2;
    tick();
    idle();
    for (int i = 0; i < 11; i++) tick();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL block_busy got=%b exp=0", busy1); end
    rS_sel = 4'd2; #1;
    checks++; if (rs_out1 !== 16'h0 || rs_out0 !== 16'h0) begin errors++; $display("FAIL block_r2 got=%h/%h exp=0", rs_out1, rs_out0); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL block_pend got=%b exp=0", stall1); end
    idle();
  endtask

  task automatic test_midclear_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    for (int i = 0; i < 15; i++) begin
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL midclr_busy_hi edge=%0d got=%b exp=1", i, busy1); end
      tick();
    end
    checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL midclr_busy_lo got=%b/%b exp=0", busy1, busy0); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 79) == 0);
      rD_we    = $urandom_range(0, 1);
      rD_sel   = 4'($urandom_range(0, 15));
      rD_in    = 16'($urandom);
      rS_sel   = ($urandom_range(0, 3) == 0) ? rD_sel : 4'($urandom_range(0, 15));
      pend_set = ($urandom_range(0, 3) == 0);
      pend_sel = 4'($urandom_range(0, 15));
      #1;
      checks++; if (rd_out1 !== exp_rd(rD_sel, 1'b1)) begin errors++; $display("FAIL rnd_rd1 n=%0d got=%h exp=%h", n, rd_out1, exp_rd(rD_sel, 1'b1)); end
      checks++; if (rs_out1 !== exp_rd(rS_sel, 1'b1)) begin errors++; $display("FAIL rnd_rs1 n=%0d got=%h exp=%h", n, rs_out1, exp_rd(rS_sel, 1'b1)); end
      checks++; if (rd_out0 !== exp_rd(rD_sel, 1'b0)) begin errors++; $display("FAIL rnd_rd0 n=%0d got=%h exp=%h", n, rd_out0, exp_rd(rD_sel, 1'b0)); end
      checks++; if (rs_out0 !== exp_rd(rS_sel, 1'b0)) begin errors++; $display("FAIL rnd_rs0 n=%0d got=%h exp=%h", n, rs_out0, exp_rd(rS_sel, 1'b0)); end
      checks++; if (stall1 !== exp_stall(1'b1)) begin errors++; $display("FAIL rnd_stall1 n=%0d got=%b exp=%b", n, stall1, exp_stall(1'b1)); end
      checks++; if (stall0 !== exp_stall(1'b0)) begin errors++; $display("FAIL rnd_stall0 n=%0d got=%b exp=%b", n, stall0, exp_stall(1'b0)); end
      checks++; if (busy1 !== (m_clr_left > 0)) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy1, (m_clr_left > 0)); end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_mem[i]  = 16'h0;
      m_pend[i] = 1'b0;
    end
    idle();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_busy_block();
    test_midclear_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
